mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the core's data-memory port, alongside the data RAM. It snoops core store cycles and pushes byte writes to its data address into a small FIFO. It serialises queued bytes as 8N1 frames on `tx_o`. It also returns a registered status word on core loads from its status address, with the same one-cycle read latency as the data RAM.

---
 rtl/mmio_uart_tx.sv | 180 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status register
// Snoops core stores to the data address into a FIFO and serialises bytes LSB first on tx_o.
module mmio_uart_tx #(
  parameter int unsigned              ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = 'h0000_0800,
  parameter int unsigned              CLK_DIV    = 16,
  parameter int unsigned              FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_enable_i,
  input  logic                  mem_w_enable_i,
  input  logic [ADDR_WIDTH-1:0] mem_w_addr_i,
  input  logic [31:0]           mem_w_data_i,
  input  logic                  mem_r_enable_i,
  input  logic [ADDR_WIDTH-1:0] mem_r_addr_i,
  output logic [31:0]           mem_r_data_o,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  full_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q;
  logic [BAUD_W-1:0]   baud_cnt_q;
  logic [2:0]          bit_idx_q;
  logic [7:0]          shift_q;
  logic                tx_q;

  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         rdata_q, rdata_d;

  logic wr_req, rd_req, push_req, stat_wr;
  logic fifo_empty, fifo_full, tx_active, bit_end;
  logic push, pop;
  logic [7:0] fifo_head;
  logic unused_wdata;

  assign wr_req     = mem_enable_i & mem_w_enable_i;
  assign rd_req     = mem_enable_i & mem_r_enable_i;
  assign push_req   = wr_req & (mem_w_addr_i == BASE_ADDR);
  assign stat_wr    = wr_req & (mem_w_addr_i == STAT_ADDR);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign tx_active  = (state_q != IDLE);
  assign bit_end    = (baud_cnt_q == BAUD_LAST);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign unused_wdata = ^mem_w_data_i[31:8];

  // full is the pre-edge value, so a push into a full FIFO is dropped even if a pop frees a slot
  assign push = push_req & ~fifo_full;
  assign pop  = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    rdata_d  = rdata_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (stat_wr & mem_w_data_i[3]) ovf_d = 1'b0;
    if (push_req & fifo_full)      ovf_d = 1'b1;
    if (rd_req) begin
      rdata_d = (mem_r_addr_i == STAT_ADDR) ?
                {28'b0, ovf_q, tx_active, fifo_empty, fifo_full} : 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_w_data_i[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= 32'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  // tx_q is loaded with the level of the state being entered, so the line is glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q    <= fifo_head;
            baud_cnt_q <= '0;
            state_q    <= START;
            tx_q       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            bit_idx_q  <= 3'd0;
            state_q    <= DATA;
            tx_q       <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            shift_q    <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= 3'd0;
              state_q   <= STOP;
              tx_q      <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (pop) begin
              shift_q <= fifo_head;
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = tx_active | ~fifo_empty;
  assign full_o       = fifo_full;
  assign mem_r_data_o = rdata_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx
// Reference model: byte queue plus frame start time; line level derived from elapsed cycles.
module tb_mmio_uart_tx;

  localparam int CD    = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h0000_0800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, wen, ren;
  logic [31:0] waddr, wdata, raddr;
  logic [31:0] rdata;
  logic        tx, busy, full;

  mmio_uart_tx #(
    .ADDR_WIDTH(32), .BASE_ADDR(BASE), .CLK_DIV(CD), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_enable_i(en), .mem_w_enable_i(wen), .mem_w_addr_i(waddr), .mem_w_data_i(wdata),
    .mem_r_enable_i(ren), .mem_r_addr_i(raddr), .mem_r_data_o(rdata),
    .tx_o(tx), .busy_o(busy), .full_o(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int          t = 0;
  logic [7:0]  mq[$];
  int          fs = 0;
  logic [7:0]  fb = 8'h00;
  bit          fact = 1'b0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_rdata = 32'h0;

  typedef struct {
    logic        en, wen;
    logic [31:0] waddr, wdata;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[9];
  logic line_rec[80];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  function automatic vec_t mk(logic e, logic w, logic [31:0] wa, logic [31:0] wd,
                              logic r, logic [31:0] ra, logic [31:0] er, logic eb);
    vec_t v;
    v.en = e; v.wen = w; v.waddr = wa; v.wdata = wd;
    v.ren = r; v.raddr = ra; v.exp_rdata = er; v.exp_busy = eb;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    fact = 1'b0;
    m_ovf = 1'b0;
    m_rdata = 32'h0;
  endtask

  function automatic bit m_active();
    return fact && ((t - fs) < 10 * CD);
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_active()) return 1'b1;
    k = (t - fs) / CD;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return fb[k-1];
  endfunction

  task automatic model_step();
    logic pre_full, pre_empty, act_pre, free;
    t++;
    pre_full  = (mq.size() == DEPTH);
    pre_empty = (mq.size() == 0);
    act_pre   = fact && ((t - fs) <= 10 * CD);
    free      = !act_pre || ((t - fs) == 10 * CD);
    if (en && ren)
      m_rdata = (raddr == BASE + 4) ? {28'b0, m_ovf, act_pre, pre_empty, pre_full} : 32'h0;
    if (en && wen && waddr == BASE + 4 && wdata[3]) m_ovf = 1'b0;
    if (!pre_empty && free) begin
      fb = mq.pop_front();
      fs = t;
      fact = 1'b1;
    end
    if (en && wen && waddr == BASE) begin
      if (pre_full) m_ovf = 1'b1;
      else mq.push_back(wdata[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    chk("tx_o", tx, m_tx());
    chk("busy_o", busy, m_active() || mq.size() != 0);
    chk("full_o", full, mq.size() == DEPTH);
    chk("mem_r_data_o", rdata, m_rdata);
  endtask

  task automatic idle_in();
    en = 0; wen = 0; ren = 0; waddr = 0; wdata = 0; raddr = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    en = 1; wen = 1; waddr = a; wdata = d; ren = 0;
    tick();
    idle_in();
  endtask

  task automatic load(input logic [31:0] a);
    en = 1; ren = 1; raddr = a; wen = 0;
    tick();
    idle_in();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 1000 && busy; i++) tick();
    chk(name, busy, 1'b0);
  endtask

  initial begin
    idle_in();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_full", full, 1'b0);
    chk("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    // address decode, enable qualification and read-hold vectors
    tbl[0] = mk(1, 1, BASE + 8, 32'h41, 0, 0,        32'h0, 0);
    tbl[1] = mk(1, 0, 0,        0,      1, BASE,     32'h0, 0);
    tbl[2] = mk(1, 0, 0,        0,      1, BASE + 4, 32'h2, 0);
    tbl[3] = mk(1, 1, BASE + 4, 32'h8,  0, 0,        32'h2, 0);
    tbl[4] = mk(0, 1, BASE,     32'h77, 0, 0,        32'h2, 0);
    tbl[5] = mk(0, 0, 0,        0,      1, BASE,     32'h2, 0);
    tbl[6] = mk(1, 0, 0,        0,      1, BASE,     32'h0, 0);
    tbl[7] = mk(1, 1, BASE + 4, 32'hFF, 1, BASE + 4, 32'h2, 0);
    tbl[8] = mk(1, 0, 0,        0,      1, BASE + 5, 32'h0, 0);
    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en; wen = tbl[i].wen; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      ren = tbl[i].ren; raddr = tbl[i].raddr;
      tick();
      chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      chk($sformatf("tbl%0d_tx", i), tx, 1'b1);
    end
    idle_in();
    repeat (10) tick();
    chk("decode_no_frame", busy, 1'b0);

    // single byte 0x55
    store(BASE, 32'h55);
    chk("sb_tx_at_push", tx, 1'b1);
    tick();
    chk("sb_tx_fall", tx, 1'b0);
    line_rec[0] = tx;
    for (int c = 1; c < 10 * CD; c++) begin tick(); line_rec[c] = tx; end
    for (int k = 0; k < 10; k++)
      for (int c = 0; c < CD; c++)
        chk($sformatf("sb_bit%0d", k), line_rec[k*CD+c], k % 2);
    tick();
    chk("sb_busy_done", busy, 1'b0);

    // back-to-back 0xA3, 0x0F
    en = 1; wen = 1; waddr = BASE; wdata = 32'hA3;
    tick();
    wdata = 32'h0F;
    tick();
    idle_in();
    line_rec[0] = tx;
    for (int c = 1; c < 20 * CD; c++) begin tick(); line_rec[c] = tx; end
    for (int f = 0; f < 2; f++) begin
      logic [7:0] b;
      b = (f == 0) ? 8'hA3 : 8'h0F;
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < CD; c++)
          chk($sformatf("b2b_f%0d_bit%0d", f, k), line_rec[f*10*CD + k*CD + c],
              (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : ((b >> (k - 1)) & 8'h1));
    end
    tick();
    chk("b2b_busy_done", busy, 1'b0);

    // overflow: ten consecutive pushes, the tenth is dropped
    for (int i = 0; i < 10; i++) begin
      en = 1; wen = 1; waddr = BASE; wdata = i;
      tick();
    end
    idle_in();
    chk("ovf_full", full, 1'b1);
    load(BASE + 4);
    chk("ovf_status", rdata, 32'hD);
    store(BASE + 4, 32'h8);
    load(BASE + 4);
    chk("ovf_cleared_bit3", rdata & 32'h8, 32'h0);
    chk("ovf_cleared_status", rdata, 32'h5);
    drain("ovf_drain");
    load(BASE + 4);
    chk("ovf_final_status", rdata, 32'h2);

    // reset during DATA bit 3 with two bytes queued
    en = 1; wen = 1; waddr = BASE;
    wdata = 32'h11; tick();
    wdata = 32'h22; tick();
    wdata = 32'h33; tick();
    idle_in();
    repeat (16) tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) tick();
    chk("rst_after_busy", busy, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int sel;
      en  = ($urandom_range(0, 7) != 0);
      wen = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 7);
      waddr = (sel < 4) ? BASE : (sel < 6) ? BASE + 4 : (sel == 6) ? BASE + 8 : $urandom;
      wdata = $urandom;
      ren = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      raddr = (sel < 2) ? BASE + 4 : (sel == 2) ? BASE : BASE + 8;
      tick();
    end
    idle_in();
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
